// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand stage: ALU control codes and the
// RV64I major opcodes this stage understands.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_NOR = 4'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/alu_operand_stage_imm_gen.sv
// Immediate generator: S-type immediate for stores, I-type for everything
// else, sign-extended from immediate bit 11 to the full datapath width.
module imm_gen
  import alu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] imm
);

  logic unused_bits;
  assign unused_bits = ^instr[19:12];

  // select S or I immediate layout by opcode and sign-extend
  always_comb begin
    if (instr[6:0] == OP_STORE) begin
      imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    end else begin
      imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage in front of the ALU: decodes an RV64I instruction into an ALU
// control code, operands and control flags, and holds them in a single-entry
// pipeline register with valid/ready handshake and flush.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      d_rd;
  logic [XLEN-1:0] imm;

  logic [3:0]      d_ctrl;
  logic [XLEN-1:0] d_a;
  logic [XLEN-1:0] d_b;
  logic [XLEN-1:0] d_sd;
  logic            d_rw;
  logic            d_mr;
  logic            d_mw;
  logic            d_br;
  logic            d_ill;
  logic            capture;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign d_rd   = instr[11:7];

  imm_gen #(.XLEN(XLEN), .ILEN(ILEN)) u_imm_gen (
    .instr (instr),
    .imm   (imm)
  );

  // in_ready must never look at in_valid, so upstream can use it freely
  assign in_ready = ~out_valid | out_ready;
  assign capture  = in_valid & in_ready & ~flush;

  // decode opcode/funct fields into ALU control, operands and flags
  always_comb begin
    d_ctrl = ALU_ADD;
    d_a    = '0;
    d_b    = '0;
    d_sd   = '0;
    d_rw   = 1'b0;
    d_mr   = 1'b0;
    d_mw   = 1'b0;
    d_br   = 1'b0;
    d_ill  = 1'b0;
    unique case (opcode)
      OP_R: begin
        if (f3 == 3'b000 && f7 == 7'b0000000)      d_ctrl = ALU_ADD;
        else if (f3 == 3'b000 && f7 == 7'b0100000) d_ctrl = ALU_SUB;
        else if (f3 == 3'b111 && f7 == 7'b0000000) d_ctrl = ALU_AND;
        else if (f3 == 3'b110 && f7 == 7'b0000000) d_ctrl = ALU_OR;
        else                                       d_ill  = 1'b1;
        d_a  = rs1_data;
        d_b  = rs2_data;
        d_rw = 1'b1;
      end
      OP_I: begin
        case (f3)
          3'b000:  d_ctrl = ALU_ADD;
          3'b111:  d_ctrl = ALU_AND;
          3'b110:  d_ctrl = ALU_OR;
          default: d_ill  = 1'b1;
        endcase
        d_a  = rs1_data;
        d_b  = imm;
        d_rw = 1'b1;
      end
      OP_LOAD: begin
        if (f3 == 3'b111) d_ill = 1'b1;
        d_a  = rs1_data;
        d_b  = imm;
        d_mr = 1'b1;
        d_rw = 1'b1;
      end
      OP_STORE: begin
        if (f3[2]) d_ill = 1'b1;
        d_a  = rs1_data;
        d_b  = imm;
        d_sd = rs2_data;
        d_mw = 1'b1;
      end
      OP_BRANCH: begin
        if (f3 == 3'b010 || f3 == 3'b011) d_ill = 1'b1;
        d_ctrl = ALU_SUB;
        d_a    = rs1_data;
        d_b    = rs2_data;
        d_br   = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    // illegal encodings go down as a harmless ADD of zeros with no side effects
    if (d_ill) begin
      d_ctrl = ALU_ADD;
      d_a    = '0;
      d_b    = '0;
      d_sd   = '0;
      d_rw   = 1'b0;
      d_mr   = 1'b0;
      d_mw   = 1'b0;
      d_br   = 1'b0;
    end
    if (d_rd == 5'd0) d_rw = 1'b0;
  end

  // single-entry pipeline register: reset > flush > capture > drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_ctrl   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      store_data <= '0;
      rd         <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      branch     <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      alu_ctrl   <= d_ctrl;
      op_a       <= d_a;
      op_b       <= d_b;
      store_data <= d_sd;
      rd         <= d_rd;
      reg_write  <= d_rw;
      mem_read   <= d_mr;
      mem_write  <= d_mw;
      branch     <= d_br;
      illegal    <= d_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: directed scenarios plus a randomized run
// checked against a transaction-level model (decode function + 1-deep queue).
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] rs1_data, rs2_data, op_a, op_b, store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write, branch, illegal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  ctrl;
    logic [63:0] a, b, sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, ill;
  } exp_t;

  alu_operand_stage #(.XLEN(64), .ILEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .store_data(store_data), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decode written straight from the instruction-set rules.
  function automatic exp_t ref_decode(logic [31:0] i, logic [63:0] r1, logic [63:0] r2);
    exp_t e;
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    logic signed [11:0] ii = i[31:20];
    logic signed [11:0] si = {i[31:25], i[11:7]};
    longint imm_i = ii;
    longint imm_s = si;
    bit ok = 1'b0;
    e = '{ctrl: 4'd2, a: 64'd0, b: 64'd0, sd: 64'd0, rd: i[11:7],
          rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, ill: 1'b0};
    if (op == 7'h33) begin
      ok = 1'b1; e.a = r1; e.b = r2; e.rw = 1'b1;
      if (f3 == 0 && f7 == 7'h00) e.ctrl = 4'd2;
      else if (f3 == 0 && f7 == 7'h20) e.ctrl = 4'd6;
      else if (f3 == 7 && f7 == 7'h00) e.ctrl = 4'd0;
      else if (f3 == 6 && f7 == 7'h00) e.ctrl = 4'd1;
      else ok = 1'b0;
    end else if (op == 7'h13) begin
      ok = (f3 inside {3'd0, 3'd6, 3'd7});
      e.ctrl = (f3 == 7) ? 4'd0 : (f3 == 6) ? 4'd1 : 4'd2;
      e.a = r1; e.b = imm_i; e.rw = 1'b1;
    end else if (op == 7'h03) begin
      ok = (f3 != 3'd7);
      e.a = r1; e.b = imm_i; e.mr = 1'b1; e.rw = 1'b1;
    end else if (op == 7'h23) begin
      ok = (f3 <= 3'd3);
      e.a = r1; e.b = imm_s; e.mw = 1'b1; e.sd = r2;
    end else if (op == 7'h63) begin
      ok = !(f3 inside {3'd2, 3'd3});
      e.ctrl = 4'd6; e.a = r1; e.b = r2; e.br = 1'b1;
    end
    if (!ok) begin
      e.ctrl = 4'd2; e.a = 0; e.b = 0; e.sd = 0;
      e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.ill = 1'b1;
    end
    if (e.rd == 0) e.rw = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h00};
    logic [6:0] op, f7;
    int k = $urandom_range(0, 5);
    op = (k == 5) ? 7'($urandom) : ops[k];
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom),
            ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    instr = 0; rs1_data = 0; rs2_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; in_valid = 1; instr = 32'h40B50533; rs1_data = 5; rs2_data = 7;
    tick(); tick();
    rst = 0; in_valid = 0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0d exp=1", in_ready); end
    total++; if ({alu_ctrl, rd, reg_write, mem_read, mem_write, branch, illegal} !== 14'd0) begin
      bad++; $display("FAIL reset_ctrl got=%h exp=0", {alu_ctrl, rd, reg_write, mem_read, mem_write, branch, illegal}); end
    total++; if ({op_a, op_b, store_data} !== 192'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", op_a, op_b, store_data); end
  endtask

  task automatic test_sub();
    idle_inputs();
    in_valid = 1; instr = 32'h40B50533; rs1_data = 5; rs2_data = 7;
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sub_valid got=%0d exp=1", out_valid); end
    total++; if (alu_ctrl !== 4'd6) begin bad++; $display("FAIL sub_ctrl got=%0d exp=6", alu_ctrl); end
    total++; if (op_a !== 64'd5 || op_b !== 64'd7) begin bad++; $display("FAIL sub_ops got=%0d,%0d exp=5,7", op_a, op_b); end
    total++; if (rd !== 5'd10 || reg_write !== 1'b1) begin bad++; $display("FAIL sub_rd got=%0d,%0d exp=10,1", rd, reg_write); end
    total++; if ({mem_read, mem_write, branch, illegal} !== 4'd0) begin
      bad++; $display("FAIL sub_flags got=%b exp=0000", {mem_read, mem_write, branch, illegal}); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sub_drain got=%0d exp=0", out_valid); end
  endtask

  task automatic test_imm();
    logic [63:0] r2;
    idle_inputs();
    in_valid = 1; instr = 32'hFFF50513; rs1_data = 0; rs2_data = 64'h1234;
    tick();
    total++; if (alu_ctrl !== 4'd2 || op_b !== 64'hFFFF_FFFF_FFFF_FFFF || op_a !== 64'd0) begin
      bad++; $display("FAIL addi got ctrl=%0d a=%h b=%h exp 2/0/ffffffffffffffff", alu_ctrl, op_a, op_b); end
    total++; if (reg_write !== 1'b1 || rd !== 5'd10) begin bad++; $display("FAIL addi_rw got=%0d rd=%0d exp=1 rd=10", reg_write, rd); end
    r2 = {$urandom, $urandom};
    instr = 32'hFE512E23; rs1_data = 64'h100; rs2_data = r2;
    tick();
    in_valid = 0;
    total++; if (op_b !== 64'hFFFF_FFFF_FFFF_FFFC || op_a !== 64'h100 || alu_ctrl !== 4'd2) begin
      bad++; $display("FAIL sw_ops got ctrl=%0d a=%h b=%h exp 2/100/fffffffffffffffc", alu_ctrl, op_a, op_b); end
    total++; if (mem_write !== 1'b1 || store_data !== r2) begin
      bad++; $display("FAIL sw_store got mw=%0d sd=%h exp mw=1 sd=%h", mem_write, store_data, r2); end
    total++; if (reg_write !== 1'b0 || mem_read !== 1'b0) begin
      bad++; $display("FAIL sw_flags got rw=%0d mr=%0d exp 0,0", reg_write, mem_read); end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2;
    idle_inputs();
    in_valid = 1; instr = 32'h007302B3; rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
    e1 = ref_decode(instr, rs1_data, rs2_data);
    tick();
    out_ready = 0;
    instr = 32'h7F50E193; rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
    e2 = ref_decode(instr, rs1_data, rs2_data);
    #1;
    for (int c = 0; c < 3; c++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready cyc=%0d got=%0d exp=0", c, in_ready); end
      total++; if (out_valid !== 1'b1 || alu_ctrl !== e1.ctrl || op_a !== e1.a || op_b !== e1.b || rd !== e1.rd || reg_write !== e1.rw) begin
        bad++; $display("FAIL hold_out cyc=%0d got v=%0d ctrl=%0d a=%h b=%h rd=%0d exp ctrl=%0d a=%h b=%h rd=%0d",
                        c, out_valid, alu_ctrl, op_a, op_b, rd, e1.ctrl, e1.a, e1.b, e1.rd); end
      tick();
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%0d exp=1", in_ready); end
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || alu_ctrl !== e2.ctrl || op_a !== e2.a || op_b !== e2.b || rd !== e2.rd || reg_write !== e2.rw) begin
      bad++; $display("FAIL second_out got v=%0d ctrl=%0d a=%h b=%h rd=%0d exp ctrl=%0d a=%h b=%h rd=%0d",
                      out_valid, alu_ctrl, op_a, op_b, rd, e2.ctrl, e2.a, e2.b, e2.rd); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL no_dup got=%0d exp=0", out_valid); end
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid = 1; flush = 1; instr = 32'h40B50533; rs1_data = 5; rs2_data = 7;
    tick();
    flush = 0; in_valid = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_capture got=%0d exp=0", out_valid); end
    in_valid = 1;
    tick();
    out_ready = 0; flush = 1;
    tick();
    flush = 0; in_valid = 0; out_ready = 1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_held got=%0d exp=0", out_valid); end
    in_valid = 1;
    tick();
    rst = 1; flush = 1;
    tick();
    rst = 0; flush = 0; in_valid = 0;
    total++; if (out_valid !== 1'b0 || alu_ctrl !== 4'd0 || op_a !== 64'd0 || op_b !== 64'd0 || rd !== 5'd0 || reg_write !== 1'b0) begin
      bad++; $display("FAIL rst_flush got v=%0d ctrl=%0d a=%h b=%h rd=%0d rw=%0d exp all 0",
                      out_valid, alu_ctrl, op_a, op_b, rd, reg_write); end
  endtask

  task automatic test_illegal();
    idle_inputs();
    in_valid = 1; instr = 32'h0000007F; rs1_data = 64'hAAAA; rs2_data = 64'h5555;
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_ctrl !== 4'd2) begin
      bad++; $display("FAIL illegal got v=%0d ill=%0d ctrl=%0d exp 1,1,2", out_valid, illegal, alu_ctrl); end
    total++; if (op_a !== 64'd0 || op_b !== 64'd0 || {reg_write, mem_read, mem_write, branch} !== 4'd0) begin
      bad++; $display("FAIL illegal_zero got a=%h b=%h flags=%b exp 0", op_a, op_b, {reg_write, mem_read, mem_write, branch}); end
    in_valid = 1; instr = 32'h00B50033; // add x0,x10,x11
    tick();
    in_valid = 0;
    total++; if (reg_write !== 1'b0 || rd !== 5'd0 || alu_ctrl !== 4'd2 || illegal !== 1'b0) begin
      bad++; $display("FAIL rd0 got rw=%0d rd=%0d ctrl=%0d ill=%0d exp 0,0,2,0", reg_write, rd, alu_ctrl, illegal); end
    tick();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    bit acc;
    idle_inputs();
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 9) == 0);
      instr     = rand_instr();
      rs1_data  = {$urandom, $urandom};
      rs2_data  = {$urandom, $urandom};
      #1;
      total++; if (out_valid !== (q.size() != 0)) begin
        bad++; $display("FAIL rnd_valid cyc=%0d got=%0d exp=%0d", c, out_valid, q.size() != 0); end
      total++; if (in_ready !== ((q.size() == 0) || out_ready)) begin
        bad++; $display("FAIL rnd_in_ready cyc=%0d got=%0d", c, in_ready); end
      if (q.size() != 0) begin
        e = q[0];
        total++; if (alu_ctrl !== e.ctrl || op_a !== e.a || op_b !== e.b || rd !== e.rd) begin
          bad++; $display("FAIL rnd_data cyc=%0d got ctrl=%0d a=%h b=%h rd=%0d exp ctrl=%0d a=%h b=%h rd=%0d",
                          c, alu_ctrl, op_a, op_b, rd, e.ctrl, e.a, e.b, e.rd); end
        total++; if ({reg_write, mem_read, mem_write, branch, illegal} !== {e.rw, e.mr, e.mw, e.br, e.ill}) begin
          bad++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", c,
                          {reg_write, mem_read, mem_write, branch, illegal}, {e.rw, e.mr, e.mw, e.br, e.ill}); end
        if (e.mw) begin
          total++; if (store_data !== e.sd) begin
            bad++; $display("FAIL rnd_store cyc=%0d got=%h exp=%h", c, store_data, e.sd); end
        end
      end
      acc = in_valid && ((q.size() == 0) || out_ready);
      if (flush) q.delete();
      else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(ref_decode(instr, rs1_data, rs2_data));
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_sub();
    test_imm();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX stage that sits directly upstream of the 64-bit ALU.
- Decodes a 32-bit RV64I instruction into the ALU's 4-bit control code and generates the immediate.
- Selects operands A/B and registers everything, plus control flags, in a single-entry pipeline register with valid/ready handshake and flush.
- Its outputs drive the ALU's alu_ctrl/a/b inputs and the downstream EX/MEM control path.

Parameters:
- XLEN, 64, datapath width of operands, immediates and register data.
- ILEN, 32, instruction width.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  squash stage contents (branch redirect)
- in_valid  input  1  instr/rs1_data/rs2_data valid
- in_ready  output  1  stage can accept this cycle
- instr  input  ILEN  instruction word
- rs1_data  input  XLEN  register file read port 1
- rs2_data  input  XLEN  register file read port 2
- out_valid  output  1  registered contents valid
- out_ready  input  1  downstream accepts this cycle
- alu_ctrl  output  4  ALU op: 0 AND, 1 OR, 2 ADD, 6 SUB (7 NOR never generated)
- op_a  output  XLEN  ALU operand A
- op_b  output  XLEN  ALU operand B
- store_data  output  XLEN  rs2_data captured for stores
- rd  output  5  destination register
- reg_write  output  1  write rd at writeback
- mem_read  output  1  load
- mem_write  output  1  store
- branch  output  1  conditional branch (compare via SUB)
- illegal  output  1  unsupported encoding

Behaviour:
- Reset: all registered outputs are 0 (out_valid=0, alu_ctrl=0, op_a=op_b=store_data=0, rd=0, all flags 0).
- in_ready is combinational: in_ready = ~out_valid | out_ready. It must not depend on in_valid.
- Capture occurs when in_valid & in_ready. Next cycle: out_valid=1 with decoded fields. Latency is 1 cycle.
- Hold: when out_valid & ~out_ready, every output stays stable and in_ready=0.
- Drain: out_valid & out_ready & ~in_valid makes out_valid=0 next cycle. Data fields may hold stale values.
- Flush, synchronous: out_valid=0 next cycle regardless of in_valid/out_ready. Flush beats capture in the same cycle, and the flushed-cycle input is dropped.
- rst beats flush.
- Decode, opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]:
  - 0110011 R: f3=000,f7=0000000 ADD; f3=000,f7=0100000 SUB; f3=111,f7=0 AND; f3=110,f7=0 OR. op_a=rs1, op_b=rs2, reg_write=1.
  - 0010011 I: f3=000 ADDI; f3=111 ANDI; f3=110 ORI. op_b=sext(instr[31:20]), reg_write=1.
  - 0000011 load: f3 in {000..011,100..110}. ADD, op_b=sext(instr[31:20]), mem_read=1, reg_write=1.
  - 0100011 store: f3 in {000..011}. ADD, op_b=sext({instr[31:25],instr[11:7]}), mem_write=1, store_data=rs2.
  - 1100011 branch: f3 in {000,001,100,101,110,111}. SUB, op_a=rs1, op_b=rs2, branch=1.
  - Anything else, including unlisted f3/f7 combos: illegal=1, alu_ctrl=2, op_a=op_b=0, all other flags 0. out_valid still asserts so downstream can trap.
- rd=instr[11:7] always captured. If rd==0, reg_write is forced to 0.
- Sign extension replicates the immediate's bit 11 to bit XLEN-1, e.g. 0xFFF becomes 0xFFFF_FFFF_FFFF_FFFF.

Decomposition:
- Shared package alu_pkg:
  - localparams ALU_AND=4'd0, ALU_OR=4'd1, ALU_ADD=4'd2, ALU_SUB=4'd6, ALU_NOR=4'd7.
  - Opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH.
- One combinational sub-module imm_gen (instr in, I/S sign-extended XLEN immediate out, selected by opcode).
- Decode logic and the pipeline register live in alu_operand_stage.

Test Plan:
- rst held 2 cycles, then released with in_valid=0 -> out_valid=0, in_ready=1, all outputs 0.
- instr=0x40B50533 (sub x10,x10,x11), rs1=5, rs2=7, in_valid=1, out_ready=1 -> next cycle out_valid=1, alu_ctrl=6, op_a=5, op_b=7, rd=10, reg_write=1.
- instr=0xFFF50513 (addi x10,x10,-1), rs1=0 -> alu_ctrl=2, op_b=0xFFFF_FFFF_FFFF_FFFF. Also sw x5,-4(x2) (0xFE512E23) -> op_b=0xFFFF_FFFF_FFFF_FFFC, mem_write=1, store_data=rs2, reg_write=0.
- Back-pressure: out_ready=0 for 3 cycles with a second instr offered -> in_ready=0, outputs unchanged. After out_ready=1, the second instr appears the cycle after acceptance with no loss or duplication.
- flush=1 in the same cycle as in_valid=1 -> next cycle out_valid=0. rst and flush together -> reset state.
- instr=0x0000007F (unknown opcode) -> out_valid=1, illegal=1, alu_ctrl=2, op_a=op_b=0, reg_write=mem_read=mem_write=branch=0.
